// File: rtl/imem_load_ctrl.sv
// Program-load controller: shares the instruction RAM port between CPU fetch and a byte-serial
// loader, packs bytes little-endian into words, then flushes the pipeline.
module imem_load_ctrl #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [31:0]       cpu_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    output logic              cpu_stall,
    output logic              cpu_flush,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {StIdle, StDrain, StLoad, StCommit, StFlush} state_e;

    state_e            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_word_count;
    logic [1:0]        r_byte_idx;
    logic [31:0]       r_wbuf;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic              r_err;

    logic              w_accept;
    logic              w_full;
    logic [31:0]       w_word;
    logic              w_unused;

    assign w_accept = (r_state == StLoad) && ld_valid;
    // Count is bumped when a write is scheduled, so the MSB marks "RAM full" without lag.
    assign w_full   = r_word_count[ADDR_W];
    assign w_unused = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

    // Upper lanes of r_wbuf are always zero, so a partial word comes out zero-padded.
    always_comb begin
        w_word = r_wbuf;
        w_word[8*r_byte_idx +: 8] = ld_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_ptr        <= '0;
            r_word_count <= '0;
            r_byte_idx   <= '0;
            r_wbuf       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_we <= 1'b0;
            // Advance after each write; the final slot's write leaves the pointer frozen.
            if (r_we && !w_full) begin
                r_ptr <= r_ptr + 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (ld_start) begin
                        r_state      <= StDrain;
                        r_ptr        <= '0;
                        r_word_count <= '0;
                        r_byte_idx   <= '0;
                        r_wbuf       <= '0;
                        r_err        <= 1'b0;
                    end
                end
                StDrain: r_state <= StLoad;
                StLoad: begin
                    if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 1'b1;
                        if (w_full) begin
                            r_err <= 1'b1;
                        end else if (r_byte_idx == 2'd3 || ld_last) begin
                            r_we         <= 1'b1;
                            r_wdata      <= w_word;
                            r_word_count <= r_word_count + 1'b1;
                            r_wbuf       <= '0;
                        end else begin
                            r_wbuf <= w_word;
                        end
                        if (ld_last) begin
                            r_state    <= StCommit;
                            r_byte_idx <= '0;
                        end
                    end
                end
                StCommit: r_state <= StFlush;
                StFlush:  r_state <= StIdle;
                default:  r_state <= StIdle;
            endcase
        end
    end

    assign ld_busy    = (r_state != StIdle);
    assign cpu_stall  = ld_busy;
    assign ld_ready   = (r_state == StLoad);
    assign cpu_flush  = (r_state == StFlush);
    assign ld_done    = (r_state == StFlush);
    assign ram_addr   = ld_busy ? r_ptr : cpu_addr[ADDR_W+1:2];
    assign ram_we     = r_we;
    assign ram_wdata  = r_wdata;
    assign ld_err     = r_err;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: a 12-bit instance for normal loads and a 2-bit
// instance for the overflow case.
module tb_imem_load_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_start = 1'b0, ld_start2 = 1'b0;
    logic        ld_valid = 1'b0, ld_last = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic [31:0] cpu_addr = '0;

    logic        ld_ready, ram_we, cpu_stall, cpu_flush, ld_busy, ld_done, ld_err;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [12:0] word_count;

    logic        ld_ready2, ram_we2, cpu_stall2, cpu_flush2, ld_busy2, ld_done2, ld_err2;
    logic [1:0]  ram_addr2;
    logic [31:0] ram_wdata2;
    logic [2:0]  word_count2;

    int checks = 0, errors = 0;
    int done_cnt = 0, done_cnt2 = 0, pulse_mism = 0;
    logic [31:0] wa[$], wd[$], wa2[$], wd2[$];

    imem_load_ctrl #(.ADDR_W(12)) u_dut (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready), .cpu_addr(cpu_addr),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .cpu_stall(cpu_stall),
        .cpu_flush(cpu_flush), .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err),
        .word_count(word_count)
    );

    imem_load_ctrl #(.ADDR_W(2)) u_ovf (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start2), .ld_valid(ld_valid),
        .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready2), .cpu_addr(cpu_addr),
        .ram_addr(ram_addr2), .ram_we(ram_we2), .ram_wdata(ram_wdata2),
        .cpu_stall(cpu_stall2), .cpu_flush(cpu_flush2), .ld_busy(ld_busy2),
        .ld_done(ld_done2), .ld_err(ld_err2), .word_count(word_count2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_we)  begin wa.push_back(32'(ram_addr));  wd.push_back(ram_wdata);  end
        if (ram_we2) begin wa2.push_back(32'(ram_addr2)); wd2.push_back(ram_wdata2); end
        if (ld_done)  done_cnt++;
        if (ld_done2) done_cnt2++;
        if (ld_done !== cpu_flush || ld_done2 !== cpu_flush2) pulse_mism++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int sel, input int idx,
                          input logic [31:0] addr, input logic [31:0] data);
        if (sel == 0 && idx < wa.size()) begin
            chk({tag, "_addr"}, wa[idx], addr);
            chk({tag, "_data"}, wd[idx], data);
        end else if (sel == 1 && idx < wa2.size()) begin
            chk({tag, "_addr"}, wa2[idx], addr);
            chk({tag, "_data"}, wd2[idx], data);
        end else begin
            checks++;
            errors++;
            $error("FAIL %s: write %0d missing, expected 0x%08h @%0d", tag, idx, data, addr);
        end
    endtask

    // Presents one byte once the selected instance is ready; returns one cycle after acceptance.
    task automatic send(input int sel, input logic [7:0] b, input logic last);
        int n = 0;
        while (!(sel == 0 ? ld_ready : ld_ready2) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!(sel == 0 ? ld_ready : ld_ready2)) begin
            checks++;
            errors++;
            $error("FAIL ready_timeout: got 0 expected 1");
        end
        ld_valid = 1'b1; ld_byte = b; ld_last = last;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic start(input int sel);
        @(negedge clk);
        if (sel == 0) ld_start = 1'b1; else ld_start2 = 1'b1;
        @(negedge clk);
        ld_start = 1'b0; ld_start2 = 1'b0;
    endtask

    task automatic wait_idle(input int sel);
        int n = 0;
        while ((sel == 0 ? ld_busy : ld_busy2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'((sel == 0) ? ld_busy : ld_busy2), 32'd0);
    endtask

    initial begin
        logic [7:0] v8[8]  = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        logic [7:0] v5[5]  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};

        // Reset state
        #12;
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_stall", 32'(cpu_stall), 0);
        chk("rst_busy_ready", 32'({ld_busy, ld_ready, ld_done, cpu_flush, ld_err}), 0);
        chk("rst_wcount", 32'(word_count), 0);
        rst_n = 1'b1;

        // Idle passthrough
        cpu_addr = 32'h0000_0010;
        @(negedge clk);
        chk("idle_addr", 32'(ram_addr), 32'd4);
        chk("idle_we_stall_ready", 32'({ram_we, cpu_stall, ld_ready}), 0);

        // 8-byte load with cycle-level checks
        start(0);
        chk("drain_stall", 32'(cpu_stall), 1);
        chk("drain_ready", 32'(ld_ready), 0);
        chk("drain_addr", 32'(ram_addr), 0);
        chk("drain_wcount", 32'(word_count), 0);
        @(negedge clk);
        chk("load_ready", 32'(ld_ready), 1);
        for (int i = 0; i < 8; i++) send(0, v8[i], i == 7);
        chk("commit_we", 32'(ram_we), 1);
        chk("commit_addr", 32'(ram_addr), 1);
        chk("commit_data", ram_wdata, 32'h0010_0093);
        chk("commit_ready", 32'(ld_ready), 0);
        @(negedge clk);
        chk("flush_pulse", 32'({cpu_flush, ld_done, cpu_stall}), 32'b111);
        @(negedge clk);
        chk("after_flush", 32'({cpu_flush, ld_done, cpu_stall, ld_busy}), 0);
        chk("l8_nwr", wa.size(), 2);
        chk_wr("l8_w0", 0, 0, 0, 32'h0000_0013);
        chk_wr("l8_w1", 0, 1, 1, 32'h0010_0093);
        chk("l8_wcount", 32'(word_count), 2);
        chk("l8_err", 32'(ld_err), 0);
        chk("l8_done_cnt", done_cnt, 1);
        chk("idle_addr_back", 32'(ram_addr), 32'd4);

        // 5-byte load: partial last word
        wa.delete(); wd.delete();
        start(0);
        for (int i = 0; i < 5; i++) send(0, v5[i], i == 4);
        wait_idle(0);
        chk("l5_nwr", wa.size(), 2);
        chk_wr("l5_w0", 0, 0, 0, 32'h0403_0201);
        chk_wr("l5_w1", 0, 1, 1, 32'h0000_00AA);
        chk("l5_wcount", 32'(word_count), 2);

        // 12 bytes with valid gaps
        wa.delete(); wd.delete();
        start(0);
        for (int i = 0; i < 12; i++) begin
            send(0, 8'(8'h11 + i), i == 11);
            if (i != 11) @(negedge clk);
        end
        wait_idle(0);
        chk("gap_nwr", wa.size(), 3);
        chk_wr("gap_w0", 0, 0, 0, 32'h1413_1211);
        chk_wr("gap_w1", 0, 1, 1, 32'h1817_1615);
        chk_wr("gap_w2", 0, 2, 2, 32'h1C1B_1A19);
        chk("gap_wcount", 32'(word_count), 3);

        // Overflow on the ADDR_W=2 instance
        start(1);
        for (int i = 0; i < 20; i++) begin
            send(1, 8'(i + 1), i == 19);
            if (i == 15) chk("ovf_err_b16", 32'(ld_err2), 0);
            if (i == 16) chk("ovf_err_b17", 32'(ld_err2), 1);
            if (i == 17) chk("ovf_ptr_frozen", 32'(ram_addr2), 3);
        end
        wait_idle(1);
        chk("ovf_nwr", wa2.size(), 4);
        chk_wr("ovf_w0", 1, 0, 0, 32'h0403_0201);
        chk_wr("ovf_w1", 1, 1, 1, 32'h0807_0605);
        chk_wr("ovf_w2", 1, 2, 2, 32'h0C0B_0A09);
        chk_wr("ovf_w3", 1, 3, 3, 32'h100F_0E0D);
        chk("ovf_wcount", 32'(word_count2), 4);
        chk("ovf_err_sticky", 32'(ld_err2), 1);
        chk("ovf_done_cnt", done_cnt2, 1);

        // Reset mid-load, then reload from word 0
        wa.delete(); wd.delete();
        cpu_addr = '0;
        start(0);
        for (int i = 0; i < 6; i++) send(0, 8'(8'h40 + i), 1'b0);
        chk("mid_busy", 32'(ld_busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_outs",
            32'({ld_ready, ram_we, cpu_stall, cpu_flush, ld_busy, ld_done, ld_err}), 0);
        chk("mid_rst_addr", 32'(ram_addr), 0);
        chk("mid_rst_wdata", ram_wdata, 0);
        chk("mid_rst_wcount", 32'(word_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wa.delete(); wd.delete();
        start(0);
        chk("re_wcount0", 32'(word_count), 0);
        send(0, 8'hA1, 1'b0); send(0, 8'hB2, 1'b0);
        send(0, 8'hC3, 1'b0); send(0, 8'hD4, 1'b1);
        wait_idle(0);
        chk("re_nwr", wa.size(), 1);
        chk_wr("re_w0", 0, 0, 0, 32'hD4C3_B2A1);
        chk("re_wcount", 32'(word_count), 1);
        chk("pulse_coincident", pulse_mism, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
